// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel layout and colours
// used by the timing controller and the page renderers.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int PX_W      = 12;
  localparam int BLUE_LSB  = 8;
  localparam int GREEN_LSB = 4;
  localparam int RED_LSB   = 0;

  typedef logic [PX_W-1:0] pixel_t;

  typedef struct packed {
    logic [3:0] blue;
    logic [3:0] green;
    logic [3:0] red;
  } rgb_t;

  localparam pixel_t COL_BLACK   = 12'h000;
  localparam pixel_t COL_WHITE   = 12'hfff;
  localparam pixel_t COL_RED     = 12'h00f;
  localparam pixel_t COL_GREEN   = 12'h0f0;
  localparam pixel_t COL_BLUE    = 12'hf00;
  localparam pixel_t COL_YELLOW  = 12'h0ff;
  localparam pixel_t COL_CYAN    = 12'hff0;
  localparam pixel_t COL_MAGENTA = 12'hf0f;

  function automatic rgb_t px_split(pixel_t p);
    return rgb_t'(p);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Coordinate / pixel bus between the timing controller
// and the page renderers.
interface vga_timing_ctrl_if;
  import vga_pkg::*;

  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       active;
  logic       frame_start;
  pixel_t     pixel_data;

  modport master (
    output x_pos,
    output y_pos,
    output active,
    output frame_start,
    input  pixel_data
  );

  modport slave (
    input  x_pos,
    input  y_pos,
    input  active,
    input  frame_start,
    output pixel_data
  );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a per-bit reset value,
// used to line sync/enable up with the renderer latency.
module vga_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             vga_rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++)
        stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA timing: coordinates out to the pages,
// latency-aligned sync and blanked RGB out to the pins.
module vga_timing_ctrl #(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_LAT = 1
) (
  input  logic              vga_clk,
  input  logic              vga_rst,
  vga_timing_ctrl_if.master page,
  output logic              hs,
  output logic              vs,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [2:0] DLY_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          h_vis, v_vis, active;
  logic          hs_raw, vs_raw;
  logic [2:0]    dly;
  logic          hs_q, vs_q;
  vga_pkg::rgb_t rgb_q, rgb_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_vis  = h_q < H_VIS;
  assign v_vis  = v_q < V_VIS;
  assign active = h_vis & v_vis;
  assign hs_raw = (h_q >= HS_BEG && h_q < HS_END) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw = (v_q >= VS_BEG && v_q < VS_END) ? SYNC_POL : ~SYNC_POL;

  assign page.x_pos  = h_vis ? h_q : '0;
  assign page.y_pos  = v_vis ? v_q : '0;
  assign page.active = active;
  // Counters sit at (0,0) during reset; keep the pulse quiet until release.
  assign page.frame_start = ~vga_rst & (h_q == '0) & (v_q == '0);

  vga_delay_line #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   (3),
    .RST_VAL (DLY_RST)
  ) u_align (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .d_i     ({hs_raw, vs_raw, active}),
    .q_o     (dly)
  );

  assign rgb_d = dly[0] ? vga_pkg::px_split(page.pixel_data) : '0;

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      rgb_q <= '0;
    end else begin
      hs_q  <= dly[2];
      vs_q  <= dly[1];
      rgb_q <= rgb_d;
    end
  end

  assign hs    = hs_q;
  assign vs    = vs_q;
  assign vga_r = rgb_q.red;
  assign vga_g = rgb_q.green;
  assign vga_b = rgb_q.blue;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl, with a shortened
// vertical frame (13 lines) so whole frames fit the run.
module tb_vga_timing_ctrl;

  localparam int PIPE_LAT = 1;
  localparam int V_ACT = 6;
  localparam int V_FPT = 2;
  localparam int V_SY  = 2;
  localparam int V_BPT = 3;
  localparam int RST   = -1;

  initial begin
    if (PIPE_LAT < 1 || PIPE_LAT > 4)
      $fatal(1, "FAIL pipe_lat: got %0d, need 1..4", PIPE_LAT);
  end

  logic       vga_clk = 1'b0;
  logic       vga_rst = 1'b1;
  logic       white   = 1'b0;
  logic       hs, vs;
  logic [3:0] vga_r, vga_g, vga_b;

  vga_timing_ctrl_if page ();

  vga_timing_ctrl #(
    .V_ACTIVE (V_ACT),
    .V_FP     (V_FPT),
    .V_SYNC   (V_SY),
    .V_BP     (V_BPT),
    .SYNC_POL (1'b0),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .page    (page),
    .hs      (hs),
    .vs      (vs),
    .vga_r   (vga_r),
    .vga_g   (vga_g),
    .vga_b   (vga_b)
  );

  always #20 vga_clk = ~vga_clk;

  // Page renderer model: one registered stage.
  always @(posedge vga_clk)
    page.pixel_data <= white ? 12'hfff
                     : {page.x_pos[3:0], page.y_pos[3:0], 4'h5};

  typedef enum int {
    F_X, F_Y, F_ACT, F_FS, F_HS, F_VS, F_RGB,
    F_NACT, F_NHS, F_NVS, F_NFS, F_HSFALL
  } fld_e;

  typedef struct {
    int    cyc;
    fld_e  f;
    int    exp;
    string name;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  int   cyc = 0;
  int   n_act = 0, n_hs = 0, n_vs = 0, n_fs = 0;
  int   hs_fall = -1;
  logic hs_prev = 1'b1;

  task automatic ex(input int c, input fld_e f, input int e,
                    input string n);
    item_t it;
    it.cyc  = c;
    it.f    = f;
    it.exp  = e;
    it.name = n;
    sb.push_back(it);
  endtask

  function automatic int observe(fld_e f);
    case (f)
      F_X:      return int'(page.x_pos);
      F_Y:      return int'(page.y_pos);
      F_ACT:    return int'(page.active);
      F_FS:     return int'(page.frame_start);
      F_HS:     return int'(hs);
      F_VS:     return int'(vs);
      F_RGB:    return int'({vga_b, vga_g, vga_r});
      F_NACT:   return n_act;
      F_NHS:    return n_hs;
      F_NVS:    return n_vs;
      F_NFS:    return n_fs;
      F_HSFALL: return hs_fall;
      default:  return -99;
    endcase
  endfunction

  // Monitor: cycle index restarts at 0 on the first cycle after reset.
  always @(negedge vga_clk) begin
    item_t it;
    int    tag;
    int    got;
    tag = vga_rst ? RST : cyc;
    while (sb.size() > 0 && sb[0].cyc == tag) begin
      it  = sb.pop_front();
      got = observe(it.f);
      checks++;
      if (got != it.exp) begin
        errors++;
        $display("FAIL %s @cyc %0d: got 'h%0h, want 'h%0h",
                 it.name, tag, got, it.exp);
      end
    end
    if (vga_rst) begin
      cyc     = 0;
      n_act   = 0;
      n_hs    = 0;
      n_vs    = 0;
      n_fs    = 0;
      hs_fall = -1;
      hs_prev = 1'b1;
    end else begin
      n_act += int'(page.active);
      n_fs  += int'(page.frame_start);
      n_hs  += int'(!hs);
      n_vs  += int'(!vs);
      if (hs_prev && !hs) hs_fall = cyc;
      hs_prev = hs;
      cyc++;
    end
  end

  initial begin
    // Initial reset state.
    ex(RST, F_HS, 1, "rst_hs");    ex(RST, F_VS, 1, "rst_vs");
    ex(RST, F_RGB, 0, "rst_rgb");  ex(RST, F_FS, 0, "rst_fs");
    // First cycle after release.
    ex(0, F_FS, 1, "c0_fs");   ex(0, F_X, 0, "c0_x");
    ex(0, F_Y, 0, "c0_y");     ex(0, F_ACT, 1, "c0_act");
    ex(0, F_HS, 1, "c0_hs");   ex(0, F_VS, 1, "c0_vs");
    ex(0, F_RGB, 0, "c0_rgb");
    ex(1, F_FS, 0, "c1_fs");   ex(1, F_X, 1, "c1_x");
    ex(1, F_RGB, 0, "c1_rgb");
    ex(2, F_RGB, 'h005, "px_0_0");
    ex(7, F_RGB, 'h505, "px_5_0");
    ex(639, F_X, 639, "x_last");  ex(639, F_ACT, 1, "act_last");
    ex(640, F_X, 0, "x_blank");   ex(640, F_ACT, 0, "act_off");
    ex(641, F_RGB, 'hf05, "px_639_0");
    ex(642, F_RGB, 0, "px_640_0");
    ex(657, F_HS, 1, "hs_pre");   ex(658, F_HS, 0, "hs_first");
    ex(753, F_HS, 0, "hs_last");  ex(754, F_HS, 1, "hs_post");
    ex(800, F_X, 0, "l1_x");      ex(800, F_Y, 1, "l1_y");
    ex(800, F_ACT, 1, "l1_act");  ex(800, F_FS, 0, "l1_fs");
    ex(800, F_NACT, 640, "line_act_cnt");
    ex(800, F_NHS, 96, "line_hs_cnt");
    ex(800, F_HSFALL, 658, "hs_fall_l0");
    ex(805, F_RGB, 'h315, "px_3_1");
    ex(1600, F_NHS, 192, "hs_cnt_2l");
    ex(1600, F_HSFALL, 1458, "hs_fall_l1");
    ex(4639, F_X, 639, "lastpx_x");  ex(4639, F_Y, 5, "lastpx_y");
    ex(4639, F_ACT, 1, "lastpx_act");
    ex(4640, F_ACT, 0, "after_lastpx");
    ex(4641, F_RGB, 'hf55, "px_639_5");
    ex(4800, F_ACT, 0, "vblank_act"); ex(4800, F_Y, 0, "vblank_y");
    ex(4812, F_RGB, 0, "vblank_rgb");
    ex(6401, F_VS, 1, "vs_pre");   ex(6402, F_VS, 0, "vs_first");
    ex(8001, F_VS, 0, "vs_last");  ex(8002, F_VS, 1, "vs_post");
    ex(10399, F_ACT, 0, "end_act"); ex(10399, F_FS, 0, "end_fs");
    ex(10400, F_FS, 1, "f1_fs");   ex(10400, F_X, 0, "f1_x");
    ex(10400, F_Y, 0, "f1_y");     ex(10400, F_ACT, 1, "f1_act");
    ex(10400, F_NFS, 1, "frame_fs_cnt");
    ex(10400, F_NVS, 1600, "frame_vs_cnt");
    ex(10400, F_NACT, 3840, "frame_act_cnt");
    // Second frame: page drives constant white.
    ex(10412, F_RGB, 'hfff, "w_px_10");
    ex(11041, F_RGB, 'hfff, "w_px_639");
    ex(11042, F_RGB, 0, "w_px_640");
    ex(15212, F_RGB, 0, "w_line6");
    ex(20012, F_RGB, 0, "w_line12");
    // Third frame: reset at (300,2).
    ex(22699, F_X, 299, "pre_rst_x"); ex(22699, F_Y, 2, "pre_rst_y");
    ex(22699, F_RGB, 'hfff, "pre_rst_rgb");
    ex(RST, F_HS, 1, "mid_rst_hs");   ex(RST, F_VS, 1, "mid_rst_vs");
    ex(RST, F_RGB, 0, "mid_rst_rgb"); ex(RST, F_FS, 0, "mid_rst_fs");
    ex(RST, F_X, 0, "mid_rst_x");     ex(RST, F_Y, 0, "mid_rst_y");
    ex(0, F_FS, 1, "r0_fs");  ex(0, F_X, 0, "r0_x");
    ex(0, F_Y, 0, "r0_y");    ex(0, F_ACT, 1, "r0_act");
    ex(1, F_FS, 0, "r1_fs");  ex(1, F_X, 1, "r1_x");
    ex(1, F_RGB, 0, "r1_rgb");
    ex(2, F_RGB, 'hfff, "r2_rgb");
    ex(642, F_RGB, 0, "r_px_640");
    ex(800, F_Y, 1, "r_l1_y");
    ex(800, F_NACT, 640, "r_line_act");
    ex(800, F_NHS, 96, "r_line_hs");
    ex(800, F_HSFALL, 658, "r_hs_fall");

    repeat (3) @(posedge vga_clk);
    #1 vga_rst = 1'b0;
    repeat (10400) @(posedge vga_clk);
    #1 white = 1'b1;
    repeat (12300) @(posedge vga_clk);
    #1 vga_rst = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1 vga_rst = 1'b0;
    repeat (850) @(posedge vga_clk);
    #1;

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never reached, still pending at cyc %0d, want cyc %0d",
               sb[0].name, cyc, sb[0].cyc);
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
